// File: rtl/rc_arbiter_if.sv
// Request/grant and ICAP-controller signal bundle for rc_arbiter.
// slave = arbiter side, master = requester / icapi side.
interface rc_arbiter_if;
  logic [2:0]  req;
  logic [5:0]  req_rm;
  logic [2:0]  gnt;
  logic [2:0]  isolate;
  logic [2:0]  done;
  logic [2:0]  err;
  logic        busy;
  logic        rc_start;
  logic        rc_bop;
  logic [31:0] rc_baddr;
  logic [31:0] rc_bsize;
  logic        rc_done;

  modport slave (
    input  req, req_rm, rc_done,
    output gnt, isolate, done, err, busy,
    output rc_start, rc_bop, rc_baddr, rc_bsize
  );

  modport master (
    output req, req_rm, rc_done,
    input  gnt, isolate, done, err, busy,
    input  rc_start, rc_bop, rc_baddr, rc_bsize
  );
endinterface

// File: rtl/rc_arbiter.sv
// Round-robin reconfiguration arbiter for three RRs feeding one icapi.
// Skips reloads of an already-resident RM and aborts stalled loads.
module rc_arbiter #(
  parameter int unsigned HDR_SIZE = 16,
  parameter int unsigned TIMEOUT  = 4096
) (
  input logic          clock,
  input logic          rst_n,
  rc_arbiter_if.slave  bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_sel;
  logic [1:0]      r_rm;
  logic            r_inv;
  logic [1:0]      r_ptr;
  logic [2:0][1:0] r_lrm;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_err;
  logic [31:0]     r_baddr;
  logic [31:0]     r_bsize;

  logic [1:0]      w_pick;
  logic [1:0]      w_rm;
  logic            w_valid;
  logic [31:0]     w_addr;
  logic [31:0]     w_tsize;
  logic [2:0]      w_oh;
  logic [1:0]      w_lrm;
  logic            w_sel_go;
  logic            w_tout;

  // Search starts at the RR after the last one served.
  always_comb begin
    w_pick = 2'd0;
    case (r_ptr)
      2'd0:    w_pick = bus.req[1] ? 2'd1 :
                        bus.req[2] ? 2'd2 : 2'd0;
      2'd1:    w_pick = bus.req[2] ? 2'd2 :
                        bus.req[0] ? 2'd0 : 2'd1;
      default: w_pick = bus.req[0] ? 2'd0 :
                        bus.req[1] ? 2'd1 : 2'd2;
    endcase
  end

  always_comb begin
    w_rm = bus.req_rm[1:0];
    case (w_pick)
      2'd0:    w_rm = bus.req_rm[1:0];
      2'd1:    w_rm = bus.req_rm[3:2];
      default: w_rm = bus.req_rm[5:4];
    endcase
  end

  always_comb begin
    w_valid = 1'b1;
    w_addr  = '0;
    w_tsize = '0;
    case ({w_pick, w_rm})
      4'b00_00: begin w_addr = 32'h000; w_tsize = 32'd16;  end
      4'b00_01: begin w_addr = 32'h020; w_tsize = 32'd16;  end
      4'b01_00: begin w_addr = 32'h040; w_tsize = 32'd48;  end
      4'b01_01: begin w_addr = 32'h080; w_tsize = 32'd48;  end
      4'b10_00: begin w_addr = 32'h0C0; w_tsize = 32'd112; end
      4'b10_01: begin w_addr = 32'h140; w_tsize = 32'd112; end
      4'b10_10: begin w_addr = 32'h1C0; w_tsize = 32'd112; end
      default:  w_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_lrm = r_lrm[0];
    case (r_sel)
      2'd0:    w_lrm = r_lrm[0];
      2'd1:    w_lrm = r_lrm[1];
      default: w_lrm = r_lrm[2];
    endcase
  end

  assign w_oh     = 3'b001 << r_sel;
  assign w_sel_go = (r_state == S_IDLE) && (|bus.req);
  assign w_tout   = (r_state == S_WAIT) && !bus.rc_done &&
                    (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (|bus.req) w_next = S_LOAD;
      S_LOAD:
        if (r_inv)              w_next = S_IDLE;
        else if (r_rm == w_lrm) w_next = S_FINISH;
        else                    w_next = S_START;
      S_START:
        w_next = S_WAIT;
      S_WAIT:
        if (bus.rc_done) w_next = S_FINISH;
        else if (w_tout) w_next = S_IDLE;
      S_FINISH:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= 2'd0;
      r_rm    <= 2'd0;
      r_inv   <= 1'b0;
      r_ptr   <= 2'd2;
      r_lrm   <= {3{2'b11}};
      r_cnt   <= '0;
      r_err   <= '0;
      r_baddr <= 32'hFFFF_FFFF;
      r_bsize <= 32'hFFFF_FFFF;
    end else begin
      r_state <= w_next;
      r_err   <= '0;
      if (w_sel_go) begin
        r_sel <= w_pick;
        r_ptr <= w_pick;
        r_rm  <= w_rm;
        r_inv <= !w_valid;
        if (w_valid) begin
          r_baddr <= w_addr;
          r_bsize <= w_tsize + 32'(HDR_SIZE);
        end else begin
          r_err <= 3'b001 << w_pick;
        end
      end
      if (r_state == S_START)
        r_cnt <= '0;
      else if (r_state == S_WAIT)
        r_cnt <= r_cnt + CW'(1);
      for (int i = 0; i < 3; i++) begin
        if (w_oh[i] && r_state == S_WAIT) begin
          if (bus.rc_done)
            r_lrm[i] <= r_rm;
          else if (w_tout)
            r_lrm[i] <= 2'b11;
        end
      end
      if (w_tout)
        r_err <= w_oh;
    end
  end

  assign bus.gnt      = (r_state != S_IDLE) ? w_oh : 3'b000;
  assign bus.isolate  = bus.gnt;
  assign bus.done     = (r_state == S_FINISH) ? w_oh : 3'b000;
  assign bus.err      = r_err;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.rc_start = (r_state == S_START);
  assign bus.rc_bop   = 1'b1;
  assign bus.rc_baddr = r_baddr;
  assign bus.rc_bsize = r_bsize;

endmodule

// File: tb/tb_rc_arbiter.sv
// Bench for rc_arbiter: directed vector table, reset-in-WAIT case,
// and random transactions against a transaction-level reference model.
module tb_rc_arbiter;
  localparam int TB_TO = 16;

  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  rc_arbiter_if bus();

  rc_arbiter #(.HDR_SIZE(16), .TIMEOUT(TB_TO)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  int m_last;
  int m_lrm [3];
  int seg_addr [3][3] = '{'{'h000, 'h020, 0},
                          '{'h040, 'h080, 0},
                          '{'h0C0, 'h140, 'h1C0}};
  int seg_size [3] = '{16, 48, 112};
  int n_rm [3] = '{2, 2, 3};

  logic [2:0]  o_gnt, o_done, o_err;
  logic        o_st;
  logic [31:0] o_ba, o_bs;

  typedef struct {
    logic [2:0]  req;
    logic [5:0]  rm;
    int          dly;
    bit          hold;
    logic [2:0]  gnt;
    logic [31:0] baddr;
    logic [31:0] bsize;
    logic        st;
    logic [2:0]  done;
    logic [2:0]  err;
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_gnt"}, bus.gnt, 0);
    chk({nm, "_iso"}, bus.isolate, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_err"}, bus.err, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_start"}, bus.rc_start, 0);
    chk({nm, "_bop"}, bus.rc_bop, 1);
    chk({nm, "_baddr"}, bus.rc_baddr, 32'hFFFF_FFFF);
    chk({nm, "_bsize"}, bus.rc_bsize, 32'hFFFF_FFFF);
  endtask

  task automatic model_reset();
    m_last = 2;
    for (int i = 0; i < 3; i++) m_lrm[i] = 3;
  endtask

  task automatic obs();
    o_st   = o_st | bus.rc_start;
    o_done = o_done | bus.done;
    o_err  = o_err | bus.err;
  endtask

  task automatic scramble();
    bus.req     = 3'($urandom);
    bus.req_rm  = 6'($urandom);
    bus.rc_done = 1'($urandom);
  endtask

  // dly < 0: rc_done never comes; otherwise rc_done in WAIT cycle dly.
  task automatic run_txn(input logic [2:0] rq, input logic [5:0] rm,
                         input int dly, input bit hold);
    int w, r, c;
    bit ok, skip;
    logic [2:0] oh;
    o_gnt = 0; o_done = 0; o_err = 0; o_st = 0; o_ba = 0; o_bs = 0;
    @(negedge clock);
    chk("idle_busy", bus.busy, 0);
    bus.req     = rq;
    bus.req_rm  = rm;
    bus.rc_done = 1'b0;
    w = 0;
    for (int k = 3; k >= 1; k--) begin
      c = (m_last + k) % 3;
      if (rq[c]) w = c;
    end
    r    = int'(rm >> (2 * w)) & 3;
    ok   = r < n_rm[w];
    skip = ok && (m_lrm[w] == r);
    oh   = 3'(1 << w);
    m_last = w;
    @(negedge clock);
    obs();
    o_gnt = bus.gnt;
    o_ba  = bus.rc_baddr;
    o_bs  = bus.rc_bsize;
    chk("load_gnt", bus.gnt, oh);
    chk("load_iso", bus.isolate, oh);
    chk("load_busy", bus.busy, 1);
    chk("load_err", bus.err, ok ? oh & 3'b000 : oh);
    chk("load_start", bus.rc_start, 0);
    chk("load_done", bus.done, 0);
    if (ok) begin
      chk("baddr", bus.rc_baddr, seg_addr[w][r]);
      chk("bsize", bus.rc_bsize, seg_size[w] + 16);
    end
    if (!ok) begin
      if (!hold) bus.req = 3'b000;
      @(negedge clock);
      obs();
      chk("inv_busy", bus.busy, 0);
      chk("inv_err", bus.err, 0);
      chk("inv_gnt", bus.gnt, 0);
      return;
    end
    if (!hold) scramble();
    @(negedge clock);
    obs();
    if (skip) begin
      chk("skip_done", bus.done, oh);
      chk("skip_gnt", bus.gnt, oh);
      chk("skip_start", bus.rc_start, 0);
      if (!hold) bus.req = 3'b000;
      bus.rc_done = 1'b0;
      return;
    end
    chk("start", bus.rc_start, 1);
    chk("start_gnt", bus.gnt, oh);
    chk("start_done", bus.done, 0);
    if (!hold) scramble();
    for (int i = 0; i < TB_TO; i++) begin
      @(negedge clock);
      obs();
      chk("wait_start", bus.rc_start, 0);
      chk("wait_gnt", bus.gnt, oh);
      chk("wait_done", bus.done, 0);
      chk("wait_err", bus.err, 0);
      bus.rc_done = (i == dly);
      if (!hold) begin
        bus.req    = 3'($urandom);
        bus.req_rm = 6'($urandom);
      end
      if (i == dly) break;
    end
    @(negedge clock);
    obs();
    bus.rc_done = 1'b0;
    if (dly >= 0 && dly < TB_TO) begin
      chk("fin_done", bus.done, oh);
      chk("fin_gnt", bus.gnt, oh);
      m_lrm[w] = r;
    end else begin
      chk("to_err", bus.err, oh);
      chk("to_busy", bus.busy, 0);
      chk("to_gnt", bus.gnt, 0);
      chk("to_done", bus.done, 0);
      m_lrm[w] = 3;
    end
    if (!hold) bus.req = 3'b000;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.req     = 3'b000;
    bus.req_rm  = 6'b000000;
    bus.rc_done = 1'b0;
    model_reset();

    //        req     rm          dly  hold gnt     baddr  bsize st done    err
    tv[0]  = '{3'b001, 6'b000001, 2,   0, 3'b001, 'h020, 32,  1, 3'b001, 3'b000};
    tv[1]  = '{3'b111, 6'b100001, 1,   1, 3'b010, 'h040, 64,  1, 3'b010, 3'b000};
    tv[2]  = '{3'b111, 6'b100001, 1,   1, 3'b100, 'h1C0, 128, 1, 3'b100, 3'b000};
    tv[3]  = '{3'b111, 6'b100001, 1,   1, 3'b001, 'h020, 32,  0, 3'b001, 3'b000};
    tv[4]  = '{3'b111, 6'b100001, 1,   1, 3'b010, 'h040, 64,  0, 3'b010, 3'b000};
    tv[5]  = '{3'b100, 6'b110000, 0,   0, 3'b100, 0,     0,   0, 3'b000, 3'b100};
    tv[6]  = '{3'b010, 6'b000100, -1,  0, 3'b010, 'h080, 64,  1, 3'b000, 3'b010};
    tv[7]  = '{3'b010, 6'b000100, 3,   0, 3'b010, 'h080, 64,  1, 3'b010, 3'b000};
    tv[8]  = '{3'b100, 6'b000000, 0,   0, 3'b100, 'h0C0, 128, 1, 3'b100, 3'b000};
    tv[9]  = '{3'b100, 6'b100000, 5,   0, 3'b100, 'h1C0, 128, 1, 3'b100, 3'b000};
    tv[10] = '{3'b100, 6'b100000, 5,   0, 3'b100, 'h1C0, 128, 0, 3'b100, 3'b000};
    tv[11] = '{3'b001, 6'b000000, TB_TO - 1, 0, 3'b001, 'h000, 32, 1, 3'b001, 3'b000};
    tv[12] = '{3'b001, 6'b000010, 0,   0, 3'b001, 0,     0,   0, 3'b000, 3'b001};
    tv[13] = '{3'b010, 6'b001000, 0,   0, 3'b010, 0,     0,   0, 3'b000, 3'b010};
    tv[14] = '{3'b111, 6'b010000, 2,   0, 3'b100, 'h140, 128, 1, 3'b100, 3'b000};

    repeat (2) @(negedge clock);
    chk_reset("rst0");
    rst_n = 1'b1;

    foreach (tv[i]) begin
      run_txn(tv[i].req, tv[i].rm, tv[i].dly, tv[i].hold);
      chk($sformatf("t%0d_gnt", i), o_gnt, tv[i].gnt);
      chk($sformatf("t%0d_start", i), o_st, tv[i].st);
      chk($sformatf("t%0d_done", i), o_done, tv[i].done);
      chk($sformatf("t%0d_err", i), o_err, tv[i].err);
      if (tv[i].st || tv[i].err == 3'b000) begin
        chk($sformatf("t%0d_baddr", i), o_ba, tv[i].baddr);
        chk($sformatf("t%0d_bsize", i), o_bs, tv[i].bsize);
      end
    end

    // Reset while waiting on icapi, then a stray rc_done.
    @(negedge clock);
    bus.req    = 3'b001;
    bus.req_rm = 6'b000001;
    @(negedge clock);
    bus.req = 3'b000;
    @(negedge clock);
    chk("rw_start", bus.rc_start, 1);
    @(negedge clock);
    chk("rw_busy", bus.busy, 1);
    chk("rw_gnt", bus.gnt, 3'b001);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_wait");
    model_reset();
    @(negedge clock);
    rst_n       = 1'b1;
    bus.rc_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("spur_done", bus.done, 0);
      chk("spur_busy", bus.busy, 0);
    end
    bus.rc_done = 1'b0;
    run_txn(3'b111, 6'b000000, 1, 0);
    chk("post_rst_gnt", o_gnt, 3'b001);

    for (int n = 0; n < 80; n++) begin
      logic [2:0] rq;
      int d;
      rq = 3'($urandom_range(1, 7));
      d  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TB_TO - 1));
      run_txn(rq, 6'($urandom), d, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
